// File: rtl/n101_uart_tx_sched_if.sv
// Handshake bundle between the two byte requesters, the TX scheduler and the UART enqueue port.
// The scheduler connects through the slave modport; the requesters and the UART side use master.
interface n101_uart_tx_sched_if;
    logic       r0_valid;
    logic [7:0] r0_bits;
    logic       r0_last;
    logic       r0_ready;
    logic       r1_valid;
    logic [7:0] r1_bits;
    logic       r1_last;
    logic       r1_ready;
    logic       tx_valid;
    logic [7:0] tx_bits;
    logic       tx_ready;

    modport master (
        output r0_valid, r0_bits, r0_last,
        input  r0_ready,
        output r1_valid, r1_bits, r1_last,
        input  r1_ready,
        input  tx_valid, tx_bits,
        output tx_ready
    );

    modport slave (
        input  r0_valid, r0_bits, r0_last,
        output r0_ready,
        input  r1_valid, r1_bits, r1_last,
        output r1_ready,
        output tx_valid, tx_bits,
        input  tx_ready
    );
endinterface

// File: rtl/n101_uart_tx_sched.sv
// n101 UART TX scheduler: round-robin arbitration with packet lock between two byte
// requesters, a show-ahead byte FIFO in front of the UART enqueue port, and ownership of
// the UART configuration, which is only changed while the line is quiet.
module n101_uart_tx_sched #(
    parameter int          FIFO_AW   = 3,
    parameter logic [15:0] DIV_RESET = 16'd0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               cfg_wr,
    input  logic               cfg_en,
    input  logic [15:0]        cfg_div,
    input  logic               cfg_nstop,
    output logic               cfg_pending,
    n101_uart_tx_sched_if.slave bus,
    output logic               tx_en,
    output logic [15:0]        tx_div,
    output logic               tx_nstop,
    output logic [FIFO_AW:0]   fifo_count
);

    localparam int                 DEPTH      = 2 ** FIFO_AW;
    localparam logic [FIFO_AW:0]   FULL_COUNT = {1'b1, {FIFO_AW{1'b0}}};
    localparam logic [FIFO_AW:0]   COUNT_ONE  = 1;
    localparam logic [FIFO_AW-1:0] PTR_ONE    = 1;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_R0   = 2'd1,
        OWN_R1   = 2'd2
    } owner_t;

    owner_t owner_reg, owner_next;
    logic   rr_ptr_reg, rr_ptr_next;
    // Set once any packet has completed; until then r0 is preferred on a tie.
    logic   served_reg, served_next;

    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_reg;
    logic [FIFO_AW-1:0] rd_ptr_reg;
    logic [FIFO_AW:0]   count_reg;

    logic        uart_idle_reg;
    logic        cfg_pending_reg;
    logic        stage_en_reg;
    logic [15:0] stage_div_reg;
    logic        stage_nstop_reg;
    logic        tx_en_reg;
    logic [15:0] tx_div_reg;
    logic        tx_nstop_reg;

    logic [1:0] req_valid;
    logic [1:0] req_last;
    logic [1:0] req_ready;
    logic [1:0] req_accept;
    logic [7:0] req_bits [2];

    logic       fifo_full;
    logic       fifo_empty;
    logic       push;
    logic       pop;
    logic [7:0] push_bits;
    logic       apply;

    assign req_valid   = {bus.r1_valid, bus.r0_valid};
    assign req_last    = {bus.r1_last,  bus.r0_last};
    assign req_bits[0] = bus.r0_bits;
    assign req_bits[1] = bus.r1_bits;

    assign fifo_full  = (count_reg == FULL_COUNT);
    assign fifo_empty = (count_reg == '0);

    // Only the current owner is ever ready, and never while the FIFO is full (no pass-through).
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_req
            assign req_ready[gi]  = (owner_reg == owner_t'(gi + 1)) && !fifo_full;
            assign req_accept[gi] = req_valid[gi] && req_ready[gi];
        end
    endgenerate

    assign bus.r0_ready = req_ready[0];
    assign bus.r1_ready = req_ready[1];

    assign push      = |req_accept;
    assign push_bits = req_accept[1] ? req_bits[1] : req_bits[0];
    assign pop       = !fifo_empty && bus.tx_ready;

    assign bus.tx_valid = !fifo_empty;
    assign bus.tx_bits  = mem[rd_ptr_reg];

    // While disabled nothing can be on the wire, so a staged config goes out at once;
    // otherwise a disabled scheduler holding bytes could never be enabled.
    assign apply = cfg_pending_reg && !cfg_wr &&
                   (!tx_en_reg ||
                    (fifo_empty && (owner_reg == OWN_NONE) && uart_idle_reg));

    assign cfg_pending = cfg_pending_reg;
    assign tx_en       = tx_en_reg;
    assign tx_div      = tx_div_reg;
    assign tx_nstop    = tx_nstop_reg;
    assign fifo_count  = count_reg;

    // Arbiter next state: grant from NONE, hold the grant until the last byte is accepted.
    always_comb begin
        owner_next  = owner_reg;
        rr_ptr_next = rr_ptr_reg;
        served_next = served_reg;
        case (owner_reg)
            OWN_NONE: begin
                if (!cfg_pending_reg) begin
                    if (req_valid[0] && req_valid[1]) begin
                        owner_next = (served_reg && !rr_ptr_reg) ? OWN_R1 : OWN_R0;
                    end else if (req_valid[0]) begin
                        owner_next = OWN_R0;
                    end else if (req_valid[1]) begin
                        owner_next = OWN_R1;
                    end
                end
            end
            OWN_R0: begin
                if (req_accept[0] && req_last[0]) begin
                    owner_next  = OWN_NONE;
                    rr_ptr_next = 1'b0;
                    served_next = 1'b1;
                end
            end
            OWN_R1: begin
                if (req_accept[1] && req_last[1]) begin
                    owner_next  = OWN_NONE;
                    rr_ptr_next = 1'b1;
                    served_next = 1'b1;
                end
            end
            default: owner_next = OWN_NONE;
        endcase
    end

    // Arbiter state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            owner_reg  <= OWN_NONE;
            rr_ptr_reg <= 1'b0;
            served_reg <= 1'b0;
        end else begin
            owner_reg  <= owner_next;
            rr_ptr_reg <= rr_ptr_next;
            served_reg <= served_next;
        end
    end

    // FIFO storage write; contents need no reset since occupancy is tracked separately.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr_reg] <= push_bits;
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + COUNT_ONE;
                2'b01:   count_reg <= count_reg - COUNT_ONE;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Line tracking: busy from a handshake until the UART is ready with nothing offered.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            uart_idle_reg <= 1'b1;
        end else if (pop) begin
            uart_idle_reg <= 1'b0;
        end else if (bus.tx_ready && fifo_empty) begin
            uart_idle_reg <= 1'b1;
        end
    end

    // Config staging and apply; a fresh write always wins over a pending apply.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cfg_pending_reg <= 1'b0;
            stage_en_reg    <= 1'b0;
            stage_div_reg   <= DIV_RESET;
            stage_nstop_reg <= 1'b0;
            tx_en_reg       <= 1'b0;
            tx_div_reg      <= DIV_RESET;
            tx_nstop_reg    <= 1'b0;
        end else if (cfg_wr) begin
            cfg_pending_reg <= 1'b1;
            stage_en_reg    <= cfg_en;
            stage_div_reg   <= cfg_div;
            stage_nstop_reg <= cfg_nstop;
        end else if (apply) begin
            cfg_pending_reg <= 1'b0;
            tx_en_reg       <= stage_en_reg;
            tx_div_reg      <= stage_div_reg;
            tx_nstop_reg    <= stage_nstop_reg;
        end
    end

endmodule
